// File: rtl/polara_loopback_checker.sv
// Loopback receive checker: parses OpenPiton headers, tracks payload length, counts packets/errors.
// Optional build macro POLARA_LOOPBACK_CHK_PAYLOAD_EN enables payload content checking (err_code widens to 4 bits).
module polara_loopback_checker #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int MAX_PAYLOAD = 8
) (
    input  logic        chipset_clk,
    input  logic        chipset_rst,
    input  logic        clr,
    input  logic [13:0] exp_chipid,
    input  logic [7:0]  exp_xpos,
    input  logic [7:0]  exp_ypos,
    input  logic [3:0]  exp_fbits,
    input  logic [7:0]  exp_msg_type,
    input  logic [63:0] intf_chipset_data,
    input  logic        intf_chipset_val,
    output logic        intf_chipset_rdy,
    output logic [15:0] pkt_count,
    output logic [7:0]  err_count,
    output logic        err_sticky,
`ifdef POLARA_LOOPBACK_CHK_PAYLOAD_EN
    output logic [3:0]  err_code,
`else
    output logic [2:0]  err_code,
`endif
    output logic [63:0] bad_header,
    output logic        pkt_done
);

    localparam int CW = $bits(err_code);
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] MAXP = 8'(MAX_PAYLOAD);

    localparam logic [CW-1:0] C_CHIPID  = CW'(1);
    localparam logic [CW-1:0] C_XPOS    = CW'(2);
    localparam logic [CW-1:0] C_YPOS    = CW'(3);
    localparam logic [CW-1:0] C_FBITS   = CW'(4);
    localparam logic [CW-1:0] C_MSGTYPE = CW'(5);
    localparam logic [CW-1:0] C_LENGTH  = CW'(6);
    localparam logic [CW-1:0] C_TIMEOUT = CW'(7);

    typedef enum logic {
        IDLE,
        PAYLOAD
    } state_t;

    state_t         state_q, state_d;
    logic           accept;
    logic [63:0]    hdr_q;
    logic [7:0]     remaining_q;
    logic [TW-1:0]  tmr_q;
    logic [CW-1:0]  pkt_code_q;
    logic [CW-1:0]  hdr_code;
    logic [CW-1:0]  pay_code;
    logic           done;
    logic [CW-1:0]  done_code;
    logic [63:0]    done_hdr;

    assign accept = intf_chipset_val && intf_chipset_rdy;

    // Error codes rank by value: the smallest nonzero code is the one reported.
    function automatic logic [CW-1:0] merge(input logic [CW-1:0] a, input logic [CW-1:0] b);
        if (a == '0) return b;
        if (b == '0) return a;
        return (a < b) ? a : b;
    endfunction

    always_comb begin
        hdr_code = '0;
        if (intf_chipset_data[29:22] > MAXP)               hdr_code = C_LENGTH;
        if (intf_chipset_data[21:14] != exp_msg_type)      hdr_code = C_MSGTYPE;
        if (intf_chipset_data[33:30] != exp_fbits)         hdr_code = C_FBITS;
        if (intf_chipset_data[41:34] != exp_ypos)          hdr_code = C_YPOS;
        if (intf_chipset_data[49:42] != exp_xpos)          hdr_code = C_XPOS;
        if (intf_chipset_data[63:50] != exp_chipid)        hdr_code = C_CHIPID;
    end

`ifdef POLARA_LOOPBACK_CHK_PAYLOAD_EN
    localparam logic [CW-1:0] C_PAYLOAD = CW'(8);
    logic [7:0] idx_q;

    always_ff @(posedge chipset_clk) begin
        if (chipset_rst) begin
            idx_q <= 8'd1;
        end else if (accept) begin
            idx_q <= (state_q == IDLE) ? 8'd1 : idx_q + 8'd1;
        end
    end

    assign pay_code = (intf_chipset_data != {56'd0, idx_q}) ? C_PAYLOAD : '0;
`else
    assign pay_code = '0;
`endif

    always_ff @(posedge chipset_clk) begin
        if (chipset_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        done      = 1'b0;
        done_code = '0;
        done_hdr  = hdr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (intf_chipset_data[29:22] == 8'd0) begin
                        done      = 1'b1;
                        done_code = hdr_code;
                        done_hdr  = intf_chipset_data;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (remaining_q == 8'd1) begin
                        done      = 1'b1;
                        done_code = merge(pkt_code_q, pay_code);
                        state_d   = IDLE;
                    end
                end else if (tmr_q == '0) begin
                    done      = 1'b1;
                    done_code = merge(pkt_code_q, C_TIMEOUT);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-packet datapath: header copy, remaining length, inter-flit timer.
    always_ff @(posedge chipset_clk) begin
        if (chipset_rst) begin
            intf_chipset_rdy <= 1'b0;
            hdr_q            <= '0;
            remaining_q      <= '0;
            tmr_q            <= '0;
            pkt_code_q       <= '0;
        end else begin
            intf_chipset_rdy <= 1'b1;
            if (accept) begin
                tmr_q <= TMR_LOAD;
                if (state_q == IDLE) begin
                    hdr_q       <= intf_chipset_data;
                    remaining_q <= intf_chipset_data[29:22];
                    pkt_code_q  <= hdr_code;
                end else begin
                    remaining_q <= remaining_q - 8'd1;
                    pkt_code_q  <= merge(pkt_code_q, pay_code);
                end
            end else if (state_q == PAYLOAD && tmr_q != '0) begin
                tmr_q <= tmr_q - 1'b1;
            end
        end
    end

    // Status block; clr takes precedence over a packet completing in the same cycle.
    always_ff @(posedge chipset_clk) begin
        if (chipset_rst) begin
            pkt_count  <= '0;
            err_count  <= '0;
            err_sticky <= 1'b0;
            err_code   <= '0;
            bad_header <= '0;
            pkt_done   <= 1'b0;
        end else begin
            pkt_done <= done;
            if (clr) begin
                pkt_count  <= '0;
                err_count  <= '0;
                err_sticky <= 1'b0;
                err_code   <= '0;
                bad_header <= '0;
            end else if (done) begin
                if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
                if (done_code != '0) begin
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    if (err_count == 8'd0)  bad_header <= done_hdr;
                    err_sticky <= 1'b1;
                    err_code   <= done_code;
                end
            end
        end
    end

endmodule
